// File: rtl/seg_bcd_capture.sv
// seg_bcd_capture: recovers BCD digits from a multiplexed seven-segment bus.
// Samples seg_in/dig_sel, requires STABLE_CYCLES identical samples before a
// digit is accepted, decodes the pattern to BCD and assembles a full frame
// that is offered on a valid/ready handshake.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   seg_in[6:0]   segment lines, bit6=a .. bit0=g
//   dig_sel       one-hot digit strobe, bit i selects digit i
//   out_ready     consumer accepts the snapshot when high with out_valid
//   out_valid     snapshot available
//   bcd_out       snapshot digits, digit i at [4i+3:4i]
//   err_out       snapshot per-digit invalid-pattern flags
//   overflow      sticky, a completed frame was dropped
//
// Optional feature macro: SEGCAP_ACTIVE_LOW_EN inverts seg_in and dig_sel at
// the input register for a common-anode bus.
module seg_bcd_capture #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  overflow
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic {EMPTY, FULL} state_t;

  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                prev_vld_q, prev_vld_d;
  logic [IDX_W-1:0]    prev_idx_q, prev_idx_d;
  logic [6:0]          prev_seg_q, prev_seg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] wk_bcd_q, wk_bcd_d;
  logic [DIGITS-1:0]   wk_err_q, wk_err_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                ovf_q, ovf_d;

  logic                cand_vld_c;
  logic [IDX_W-1:0]    idx_c;
  logic                same_c;
  logic                accept_c;
  logic                complete_c;
  logic [DIGITS-1:0]   seen_set_c;
  logic [4:0]          dec_c;

  // Pattern to {error, bcd}; unknown patterns give 4'hF with error set.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1111110: decode = 5'h00;
      7'b0110000: decode = 5'h01;
      7'b1101101: decode = 5'h02;
      7'b1111001: decode = 5'h03;
      7'b0110011: decode = 5'h04;
      7'b1011011: decode = 5'h05;
      7'b1011111: decode = 5'h06;
      7'b1110000: decode = 5'h07;
      7'b1111111: decode = 5'h08;
      7'b1111011: decode = 5'h09;
      default:    decode = 5'h1F;
    endcase
  endfunction

  // Input stage
  always_comb begin
`ifdef SEGCAP_ACTIVE_LOW_EN
    seg_d = ~seg_in;
    sel_d = ~dig_sel;
`else
    seg_d = seg_in;
    sel_d = dig_sel;
`endif
  end

  // Candidate extraction and stability counter
  always_comb begin
    cand_vld_c = (sel_q != '0) && ((sel_q & (sel_q - DIGITS'(1))) == '0);
    idx_c = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sel_q[i]) idx_c = IDX_W'(i);
    end
    same_c = cand_vld_c && prev_vld_q && (idx_c == prev_idx_q) && (seg_q == prev_seg_q);
    prev_vld_d = cand_vld_c;
    prev_idx_d = idx_c;
    prev_seg_d = seg_q;
    if (!cand_vld_c)          cnt_d = '0;
    else if (!same_c)         cnt_d = CNT_W'(1);
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + CNT_W'(1);
    // Fires only on the transition into the saturated count.
    accept_c = same_c && (cnt_q == CNT_MAX - CNT_W'(1));
  end

  // Working frame and completion detect
  always_comb begin
    dec_c    = decode(seg_q);
    wk_bcd_d = wk_bcd_q;
    wk_err_d = wk_err_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (accept_c && (idx_c == IDX_W'(i))) begin
        wk_bcd_d[4*i +: 4] = dec_c[3:0];
        wk_err_d[i]        = dec_c[4];
      end
    end
    // sel_q is one-hot whenever accept_c is high, so it is the seen bit.
    seen_set_c = seen_q | (accept_c ? sel_q : '0);
    complete_c = accept_c && (seen_set_c == '1);
    seen_d     = complete_c ? '0 : seen_set_c;
  end

  // Output handshake FSM
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      EMPTY: begin
        if (complete_c) begin
          bcd_d   = wk_bcd_d;
          err_d   = wk_err_d;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready && complete_c) begin
          bcd_d = wk_bcd_d;
          err_d = wk_err_d;
        end else if (out_ready) begin
          state_d = EMPTY;
        end else if (complete_c) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q      <= '0;
      sel_q      <= '0;
      prev_vld_q <= 1'b0;
      prev_idx_q <= '0;
      prev_seg_q <= '0;
      cnt_q      <= '0;
      wk_bcd_q   <= '0;
      wk_err_q   <= '0;
      seen_q     <= '0;
      state_q    <= EMPTY;
      bcd_q      <= '0;
      err_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      seg_q      <= seg_d;
      sel_q      <= sel_d;
      prev_vld_q <= prev_vld_d;
      prev_idx_q <= prev_idx_d;
      prev_seg_q <= prev_seg_d;
      cnt_q      <= cnt_d;
      wk_bcd_q   <= wk_bcd_d;
      wk_err_q   <= wk_err_d;
      seen_q     <= seen_d;
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign bcd_out   = bcd_q;
  assign err_out   = err_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seg_bcd_capture.sv
// Directed bench for seg_bcd_capture with DIGITS=4, STABLE_CYCLES=4.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_seg_bcd_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] bcd_out;
  logic [3:0]  err_out;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101,
                         P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011,
                         P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111,
                         P9 = 7'b1111011, PBAD = 7'b0000001;

  seg_bcd_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
    .out_ready(out_ready), .out_valid(out_valid), .bcd_out(bcd_out),
    .err_out(err_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input int idx, input logic [6:0] pat, input int n);
    seg_in  = pat;
    dig_sel = 4'(1 << idx);
    step(n);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; seg_in = '0; dig_sel = '0; out_ready = 1'b0;
    step(2);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_bcd", 32'(bcd_out), 32'h0);
    chk("reset_err", 32'(err_out), 32'h0);
    chk("reset_ovf", 32'(overflow), 32'h0);
    rst = 1'b0;
    step(1);

    // Clean frame 7,7,7,3 with latency check on the completing digit
    put(0, P7, 6); put(1, P7, 6); put(2, P7, 6);
    put(3, P3, 4);
    chk("clean_valid_early", 32'(out_valid), 32'h0);
    step(1);
    chk("clean_valid_rise", 32'(out_valid), 32'h1);
    step(1);
    chk("clean_bcd", 32'(bcd_out), 32'h3777);
    chk("clean_err", 32'(err_out), 32'h0);
    consume();
    chk("clean_consumed", 32'(out_valid), 32'h0);

    // Glitch: a 3-cycle run of 5 on the last missing digit must not complete
    put(0, P1, 6); put(2, P4, 6); put(3, P9, 6);
    put(1, P5, 3);
    put(1, P2, 1);
    chk("glitch_no_write", 32'(out_valid), 32'h0);
    step(4);
    chk("glitch_valid", 32'(out_valid), 32'h1);
    chk("glitch_bcd", 32'(bcd_out), 32'h9421);
    consume();
    chk("glitch_consumed", 32'(out_valid), 32'h0);

    // Handshake on the same edge as the next completion
    put(0, P1, 6); put(1, P2, 6); put(2, P3, 6); put(3, P4, 6);
    chk("simA_bcd", 32'(bcd_out), 32'h4321);
    put(0, P5, 6); put(1, P6, 6); put(2, P7, 6);
    put(3, P8, 4);
    chk("simB_hold", 32'(bcd_out), 32'h4321);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("simB_valid", 32'(out_valid), 32'h1);
    chk("simB_bcd", 32'(bcd_out), 32'h8765);
    chk("simB_ovf", 32'(overflow), 32'h0);
    consume();
    chk("simB_consumed", 32'(out_valid), 32'h0);

    // Invalid pattern on digit 2 held exactly STABLE_CYCLES
    put(0, P0, 6); put(1, P8, 6); put(2, PBAD, 4); put(3, P6, 6);
    chk("inv_valid", 32'(out_valid), 32'h1);
    chk("inv_bcd", 32'(bcd_out), 32'h6F80);
    chk("inv_err", 32'(err_out), 32'h4);

    // Backpressure: second frame completes while the first is still held
    put(0, P2, 6); put(1, P2, 6); put(2, P2, 6); put(3, P2, 6);
    chk("bp_bcd_held", 32'(bcd_out), 32'h6F80);
    chk("bp_err_held", 32'(err_out), 32'h4);
    chk("bp_ovf", 32'(overflow), 32'h1);
    consume();
    chk("bp_drained", 32'(out_valid), 32'h0);
    chk("bp_ovf_sticky", 32'(overflow), 32'h1);

    // Reset mid-frame, then only digits 2-3
    put(0, P1, 6); put(1, P1, 6);
    dig_sel = '0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_ovf", 32'(overflow), 32'h0);
    put(2, P3, 6); put(3, P3, 6);
    chk("rst_no_valid", 32'(out_valid), 32'h0);

    // Illegal two-hot select must not accept anything
    seg_in = P8; dig_sel = 4'b0011;
    step(10);
    chk("illegal_no_valid", 32'(out_valid), 32'h0);
    put(0, P9, 6);
    chk("illegal_d0_only", 32'(out_valid), 32'h0);
    put(1, P9, 6);
    chk("final_valid", 32'(out_valid), 32'h1);
    chk("final_bcd", 32'(bcd_out), 32'h3399);
    chk("final_err", 32'(err_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
